// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage, decode and the
// redirect source.
package cpu_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_J     = 6'd2,
        OP_BEQ   = 6'd4,
        OP_ADDI  = 6'd8,
        OP_LW    = 6'd35,
        OP_SW    = 6'd43
    } opcode_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and decode-side
// handshake signals.
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc,instr} entries with a single-cycle flush and
// an occupancy count used by the fetch credit logic.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != FULL) | do_pop);

    // Flush discards everything, including a pop or push landing in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues word reads to a 1-cycle
// instruction memory and buffers fetched {pc,instr} pairs for decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic          clk,
    input  logic          Reset,
    fetch_stage_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occ;
    logic             empty;
    logic             pop;
    logic             push;
    logic             issue;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.imem_rvalid & inflight_q & ~bus.redirect;

    // An in-flight read already owns a slot, so the queue can never overflow.
    assign occ   = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue = ~Reset & ~bus.redirect & (occ < (CNT_W+1)'(DEPTH));

    assign push_data.pc    = inflight_pc_q;
    assign push_data.instr = bus.imem_rdata;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .Reset    (Reset),
        .flush    (bus.redirect),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .count    (count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = ~empty;
    assign bus.out_instr = bus.out_valid ? head.instr : INSTR_NOP;
    assign bus.out_pc    = bus.out_valid ? head.pc : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-of-PCs reference model plus a
// 1-cycle instruction memory, driven by directed scenarios and random traffic.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    fetch_stage_if bus ();

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: the PCs decode will see, in order, plus the one outstanding read.
    logic [31:0] m_q [$];
    logic [31:0] m_fetch_pc    = RESET_PC;
    bit          m_inflight    = 1'b0;
    logic [31:0] m_inflight_pc = '0;

    bit          resp_valid = 1'b0;
    logic [31:0] resp_addr  = '0;
    bit          cyc_req    = 1'b0;
    logic [31:0] cyc_addr   = '0;
    bit          cyc_rvalid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008003C;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic bit m_pop(input bit ready);
        return (m_q.size() > 0) && ready;
    endfunction

    function automatic bit m_issue(input bit ready, input bit redir);
        int occ;
        occ = m_q.size() + int'(m_inflight) - int'(m_pop(ready));
        return !redir && (occ < DEPTH);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle outside reset, outputs must match what the queue model says.
    always @(negedge clk) begin
        #2;
        cyc_req    = bus.imem_req;
        cyc_addr   = bus.imem_addr;
        cyc_rvalid = bus.imem_rvalid;
        if (!Reset) begin
            check_output("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check_output("out_pc", bus.out_pc, m_q[0]);
                check_output("out_instr", bus.out_instr, mem_word(m_q[0]));
            end
            check_output("imem_req", 32'(bus.imem_req), 32'(m_issue(bus.out_ready, bus.redirect)));
            if (m_issue(bus.out_ready, bus.redirect)) begin
                check_output("imem_addr", bus.imem_addr, m_fetch_pc);
            end
        end
    end

    always @(posedge clk or posedge Reset) begin : model_update
        bit          rdy;
        bit          red;
        bit          pop;
        bit          iss;
        logic [31:0] rpc;
        if (Reset) begin
            m_q.delete();
            m_inflight    = 1'b0;
            m_inflight_pc = '0;
            m_fetch_pc    = RESET_PC;
            resp_valid    = 1'b0;
            resp_addr     = '0;
        end else begin
            rdy        = bus.out_ready;
            red        = bus.redirect;
            rpc        = bus.redirect_pc;
            pop        = m_pop(rdy);
            iss        = m_issue(rdy, red);
            resp_valid = cyc_req;
            resp_addr  = cyc_addr;
            if (red) begin
                m_q.delete();
                m_inflight = 1'b0;
                m_fetch_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (cyc_rvalid && m_inflight) m_q.push_back(m_inflight_pc);
                if (iss) begin
                    m_inflight    = 1'b1;
                    m_inflight_pc = m_fetch_pc;
                    m_fetch_pc    = m_fetch_pc + 32'd4;
                end else begin
                    m_inflight = 1'b0;
                end
            end
        end
    end

    task automatic apply_stimulus(input bit ready, input bit redir, input logic [31:0] rpc, input bit spur);
        @(negedge clk);
        bus.out_ready   = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        if (resp_valid) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(resp_addr);
        end else begin
            bus.imem_rvalid = spur;
            bus.imem_rdata  = $urandom;
        end
        #3;
    endtask

    task automatic step(input bit ready);
        apply_stimulus(ready, 1'b0, 32'd0, 1'b0);
    endtask

    // Reset lands between edges; its effect on the outputs must be immediate.
    task automatic reset_assert();
        @(negedge clk);
        #4;
        Reset           = 1'b1;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        #1;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check_output("rst_imem_addr", bus.imem_addr, RESET_PC);
        check_output("rst_out_pc", bus.out_pc, 32'd0);
        check_output("rst_out_instr", bus.out_instr, 32'd0);
        @(negedge clk);
    endtask

    task automatic release_reset(input bit ready);
        @(negedge clk);
        Reset           = 1'b0;
        bus.out_ready   = ready;
        bus.redirect    = 1'b0;
        bus.imem_rvalid = 1'b0;
        #3;
    endtask

    task automatic expect_after_redirect(input logic [31:0] p0, input logic [31:0] p1);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            step(1'b1);
            if (bus.out_valid) seen = 1'b1;
        end
        check_output("redir_timeout", 32'(seen), 32'd1);
        if (seen) begin
            check_output("redir_pc0", bus.out_pc, p0);
            step(1'b1);
            check_output("redir_valid1", 32'(bus.out_valid), 32'd1);
            check_output("redir_pc1", bus.out_pc, p1);
        end
    endtask

    initial begin
        int reqs;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        repeat (2) @(negedge clk);

        // Streaming from reset: first instruction two edges after release.
        release_reset(1'b1);
        step(1'b1);
        check_output("t1_first_bubble", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check_output("t1_valid", 32'(bus.out_valid), 32'd1);
            check_output("t1_pc", bus.out_pc, 32'(4 * i));
            if (i == 0) check_output("t1_instr", bus.out_instr, 32'h2008003C);
        end

        // Decode stalled: the credit limit caps outstanding reads at DEPTH.
        reset_assert();
        release_reset(1'b0);
        reqs = int'(bus.imem_req);
        for (int i = 1; i < 10; i++) begin
            step(1'b0);
            reqs += int'(bus.imem_req);
            if (bus.out_valid) check_output("t2_held_pc", bus.out_pc, 32'd0);
        end
        check_output("t2_req_count", 32'(reqs), 32'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check_output("t2_valid", 32'(bus.out_valid), 32'd1);
            check_output("t2_pc", bus.out_pc, 32'(4 * i));
        end

        // Redirect with three queued and one read in flight.
        reset_assert();
        release_reset(1'b0);
        repeat (3) step(1'b0);
        apply_stimulus(1'b1, 1'b1, 32'h14, 1'b0);
        check_output("t3_no_req", 32'(bus.imem_req), 32'd0);
        expect_after_redirect(32'h14, 32'h18);

        // Unaligned redirect target is word-aligned.
        apply_stimulus(1'b1, 1'b1, 32'h17, 1'b0);
        step(1'b1);
        check_output("t4_req", 32'(bus.imem_req), 32'd1);
        check_output("t4_addr", bus.imem_addr, 32'h14);
        check_output("t4_gap", 32'(bus.out_valid), 32'd0);
        step(1'b1);
        step(1'b1);
        check_output("t4_pc", bus.out_pc, 32'h14);

        // PC wraps past the top of the address space.
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        expect_after_redirect(32'hFFFF_FFFC, 32'h0000_0000);

        // Mid-stream reset, then restart from RESET_PC.
        reset_assert();
        release_reset(1'b1);
        step(1'b1);
        step(1'b1);
        check_output("t5_restart_pc", bus.out_pc, RESET_PC);

        // Random traffic: stalls, redirects, spurious responses, stray resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_assert();
                release_reset(1'b1);
            end else begin
                apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                               $urandom, $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
